// File: rtl/data_memory_port.sv
// Word-addressed data RAM behind the memory-control stage: accepts one load/store,
// waits WAIT_STATES cycles, executes, pulses done, and holds the pipeline via busy.
module data_memory_port #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [4:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_ram,
   output logic        fault
);

   localparam logic [4:0] OP_LOAD  = 5'b11000;
   localparam logic [4:0] OP_STORE = 5'b11001;
   localparam int         DEPTH    = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic [3:0]             cnt;
   logic                   store_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic [31:0]            mem [DEPTH];

   logic                   accept;
   logic                   exec;
   logic                   addr_bad;
   logic [ADDR_WIDTH-1:0]  idx;

   assign accept   = (state == S_IDLE) && req && ((op == OP_LOAD) || (op == OP_STORE));
   assign exec     = (state == S_WAIT) && (cnt == 4'd0);
   assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH+2] != '0);
   assign idx      = addr_q[ADDR_WIDTH+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Every access passes through WAIT, even with zero wait states, so the
   // execute edge is always one edge after the counter has drained to zero.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_WAIT;
         S_WAIT:  if (exec)   state_nxt = S_DONE;
         S_DONE:              state_nxt = S_IDLE;
         default:             state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt      <= '0;
         fault    <= 1'b0;
         data_ram <= '0;
      end else begin
         if (accept) begin
            store_q <= (op == OP_STORE);
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT_STATES);
            fault   <= 1'b0;
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (exec) begin
            if (addr_bad)      fault    <= 1'b1;
            else if (!store_q) data_ram <= mem[idx];
         end
      end
   end

   // RAM has no reset; a store cut short by reset never reaches exec.
   always_ff @(posedge clk) begin
      if (exec && store_q && !addr_bad) mem[idx] <= wdata_q;
   end

endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port: one instance with one wait state,
// one with zero wait states, sharing clock, reset and request fields.
module tb_data_memory_port;

   localparam logic [4:0] LD = 5'b11000;
   localparam logic [4:0] ST = 5'b11001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req1 = 1'b0, req0 = 1'b0;
   logic [4:0]  op = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        busy1, done1, fault1, busy0, done0, fault0;
   logic [31:0] dr1, dr0;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   data_memory_port #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy1), .done(done1), .data_ram(dr1), .fault(fault1));

   data_memory_port #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy0), .done(done0), .data_ram(dr0), .fault(fault0));

   // Issue one request and watch 8 cycles after acceptance (cycle 1 = first after E0).
   task automatic run_access(input logic [4:0] o, input logic [31:0] a, input logic [31:0] d,
                             input bit zw, output int nb, output int nd, output int at,
                             output logic [31:0] dr, output logic f);
      @(negedge clk);
      op = o; addr = a; wdata = d;
      if (zw) req0 = 1'b1; else req1 = 1'b1;
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      nb = 0; nd = 0; at = 0; dr = 'x; f = 1'bx;
      for (int k = 1; k <= 8; k++) begin
         if (zw ? busy0 : busy1) nb++;
         if (zw ? done0 : done1) begin
            nd++; at = k;
            dr = zw ? dr0 : dr1;
            f  = zw ? fault0 : fault1;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2;
      ntot++; if (busy1 !== 1'b0)  $display("FAIL reset_busy got %b want 0", busy1);  else npass++;
      ntot++; if (done1 !== 1'b0)  $display("FAIL reset_done got %b want 0", done1);  else npass++;
      ntot++; if (dr1 !== 32'h0)   $display("FAIL reset_data got %h want 0", dr1);    else npass++;
      ntot++; if (fault1 !== 1'b0) $display("FAIL reset_fault got %b want 0", fault1); else npass++;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_access();
      int nb, nd, at; logic [31:0] dr; logic f;
      run_access(ST, 32'h10, 32'h1111_1111, 1'b0, nb, nd, at, dr, f);
      @(negedge clk);
      op = ST; addr = 32'h10; wdata = 32'hDEAD_BEEF; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      ntot++; if (busy1 !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy1); else npass++;
      rst_n = 1'b0;
      #1;
      ntot++; if ({busy1, done1, fault1} !== 3'b000)
         $display("FAIL midrst_flags got %b want 000", {busy1, done1, fault1}); else npass++;
      ntot++; if (dr1 !== 32'h0) $display("FAIL midrst_data got %h want 0", dr1); else npass++;
      repeat (3) @(negedge clk);
      ntot++; if ({busy1, done1, fault1, dr1} !== 35'h0)
         $display("FAIL midrst_hold got %b want all 0", {busy1, done1, fault1, dr1}); else npass++;
      rst_n = 1'b1;
      run_access(LD, 32'h10, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (dr !== 32'h1111_1111) $display("FAIL midrst_load got %h want 11111111", dr); else npass++;
   endtask

   task automatic test_store_load();
      int nb, nd, at; logic [31:0] dr; logic f;
      run_access(ST, 32'h04, 32'h1234_5678, 1'b0, nb, nd, at, dr, f);
      ntot++; if (nb !== 3) $display("FAIL st_busy_cycles got %0d want 3", nb); else npass++;
      ntot++; if (nd !== 1) $display("FAIL st_done_pulses got %0d want 1", nd); else npass++;
      ntot++; if (at !== 3) $display("FAIL st_done_cycle got %0d want 3", at); else npass++;
      run_access(LD, 32'h04, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (nb !== 3) $display("FAIL ld_busy_cycles got %0d want 3", nb); else npass++;
      ntot++; if (nd !== 1) $display("FAIL ld_done_pulses got %0d want 1", nd); else npass++;
      ntot++; if (dr !== 32'h1234_5678) $display("FAIL ld_data got %h want 12345678", dr); else npass++;
      ntot++; if (f !== 1'b0) $display("FAIL ld_fault got %b want 0", f); else npass++;
   endtask

   task automatic test_zero_wait();
      int nb, nd, at; logic [31:0] dr; logic f;
      run_access(ST, 32'h3FC, 32'hA5A5_A5A5, 1'b1, nb, nd, at, dr, f);
      ntot++; if (nb !== 2) $display("FAIL zw_st_busy got %0d want 2", nb); else npass++;
      run_access(LD, 32'h3FC, 32'h0, 1'b1, nb, nd, at, dr, f);
      ntot++; if (at !== 2) $display("FAIL zw_done_cycle got %0d want 2", at); else npass++;
      ntot++; if (nd !== 1) $display("FAIL zw_done_pulses got %0d want 1", nd); else npass++;
      ntot++; if (dr !== 32'hA5A5_A5A5) $display("FAIL zw_data got %h want a5a5a5a5", dr); else npass++;
   endtask

   task automatic test_misaligned();
      int nb, nd, at; logic [31:0] dr; logic f;
      run_access(ST, 32'h00, 32'hCAFE_F00D, 1'b0, nb, nd, at, dr, f);
      run_access(LD, 32'h06, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (f !== 1'b1) $display("FAIL mis_fault got %b want 1", f); else npass++;
      ntot++; if (nd !== 1) $display("FAIL mis_done got %0d want 1", nd); else npass++;
      ntot++; if (dr !== 32'h1234_5678) $display("FAIL mis_data got %h want 12345678", dr); else npass++;
      ntot++; if (fault1 !== 1'b1) $display("FAIL mis_sticky got %b want 1", fault1); else npass++;
      run_access(ST, 32'h400, 32'hBAD0_BAD0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (f !== 1'b1) $display("FAIL oor_fault got %b want 1", f); else npass++;
      run_access(LD, 32'h00, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (dr !== 32'hCAFE_F00D) $display("FAIL oor_mem0 got %h want cafef00d", dr); else npass++;
      ntot++; if (f !== 1'b0) $display("FAIL fault_clear got %b want 0", f); else npass++;
   endtask

   task automatic test_non_mem_op();
      int nb = 0, nd = 0, at; logic [31:0] dr; logic f;
      @(negedge clk);
      op = 5'b00011; addr = 32'h00; wdata = 32'hFFFF_FFFF; req1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (busy1) nb++;
         if (done1) nd++;
      end
      req1 = 1'b0;
      ntot++; if (nb !== 0) $display("FAIL nop_busy got %0d want 0", nb); else npass++;
      ntot++; if (nd !== 0) $display("FAIL nop_done got %0d want 0", nd); else npass++;
      run_access(LD, 32'h00, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (dr !== 32'hCAFE_F00D) $display("FAIL nop_mem got %h want cafef00d", dr); else npass++;
   endtask

   task automatic test_back_to_back();
      int nb, nd = 0, at; logic [31:0] dr; logic f;
      run_access(ST, 32'h20, 32'h0102_0304, 1'b0, nb, nd, at, dr, f);
      nd = 0;
      @(negedge clk);
      op = ST; addr = 32'h24; wdata = 32'h0000_AAAA; req1 = 1'b1;
      @(negedge clk);
      // Re-present a different store while the first is still in WAIT.
      addr = 32'h20; wdata = 32'h9999_9999;
      for (int k = 1; k <= 6; k++) begin
         if (done1) nd++;
         if (k == 3) req1 = 1'b0;
         @(negedge clk);
      end
      ntot++; if (nd !== 1) $display("FAIL busy_req_done got %0d want 1", nd); else npass++;
      run_access(LD, 32'h20, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (dr !== 32'h0102_0304) $display("FAIL busy_req_target got %h want 01020304", dr); else npass++;
      run_access(LD, 32'h24, 32'h0, 1'b0, nb, nd, at, dr, f);
      ntot++; if (dr !== 32'h0000_AAAA) $display("FAIL busy_req_first got %h want 0000aaaa", dr); else npass++;
   endtask

   initial begin
      test_reset();
      test_reset_mid_access();
      test_store_load();
      test_zero_wait();
      test_misaligned();
      test_non_mem_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
